// File: rtl/dmem_lsu_if.sv
// ---------------------------------------------------------------------------
// dmem_lsu_if
// Bundles the three buses around the load/store unit:
//   request  : REQ_VALID/REQ_READY handshake plus REQ_WRITE, REQ_SIZE,
//              REQ_UNS, REQ_ADDR, REQ_WDATA
//   response : RESP_VALID/RESP_READY handshake plus RESP_DATA, RESP_ERR
//   memory   : DM_WE, DM_BE, DM_ADDR, DM_WD driven by the unit,
//              DM_RD returned combinationally by the data memory
// modport slave  : the load/store unit's view
// modport master : the surrounding CPU + data memory view
// ---------------------------------------------------------------------------
interface dmem_lsu_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WRITE;
  logic [1:0]  REQ_SIZE;
  logic        REQ_UNS;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;

  logic        RESP_VALID;
  logic        RESP_READY;
  logic [31:0] RESP_DATA;
  logic        RESP_ERR;

  logic        DM_WE;
  logic [3:0]  DM_BE;
  logic [29:0] DM_ADDR;
  logic [31:0] DM_WD;
  logic [31:0] DM_RD;

  modport slave (
    input  REQ_VALID, REQ_WRITE, REQ_SIZE, REQ_UNS, REQ_ADDR, REQ_WDATA,
    output REQ_READY,
    output RESP_VALID, RESP_DATA, RESP_ERR,
    input  RESP_READY,
    output DM_WE, DM_BE, DM_ADDR, DM_WD,
    input  DM_RD
  );

  modport master (
    output REQ_VALID, REQ_WRITE, REQ_SIZE, REQ_UNS, REQ_ADDR, REQ_WDATA,
    input  REQ_READY,
    input  RESP_VALID, RESP_DATA, RESP_ERR,
    output RESP_READY,
    input  DM_WE, DM_BE, DM_ADDR, DM_WD,
    output DM_RD
  );
endinterface

// File: rtl/dmem_lsu.sv
// ---------------------------------------------------------------------------
// dmem_lsu
// Load/store initiator between the CPU memory stage and a byte-enabled,
// word-addressed data memory. Takes one byte/half/word request at a time,
// drives the memory with lane enables, merges and sign/zero-extends load
// data, and splits word-crossing accesses into two memory cycles.
//
// Ports:
//   CLK   : clock, rising edge
//   RESET : synchronous, active-high reset
//   bus   : dmem_lsu_if.slave (request, response and memory buses)
// Parameters:
//   SPLIT_UNALIGNED : 1 = split word-crossing accesses, 0 = report as error
//   DM_WORDS        : number of implemented memory words
// ---------------------------------------------------------------------------
module dmem_lsu #(
  parameter int SPLIT_UNALIGNED = 1,
  parameter int DM_WORDS        = 64
) (
  input  logic       CLK,
  input  logic       RESET,
  dmem_lsu_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC0 = 2'd1;
  localparam logic [1:0] ACC1 = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [30:0] DM_WORDS_W = 31'(DM_WORDS);
  localparam bit          SPLIT_EN   = (SPLIT_UNALIGNED != 0);

  logic [1:0]  state;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [1:0]  r_offset;
  logic [29:0] r_word;
  logic [31:0] r_wdata;
  logic        r_err;
  logic        r_cross;
  logic [31:0] merge_buf;

  logic [1:0]  req_offset;
  logic [29:0] req_word;
  logic [29:0] req_word_next;
  logic [2:0]  req_bytes;
  logic        req_cross;
  logic        req_err;

  logic [3:0]  size_mask;
  logic [7:0]  lane_span;
  logic [63:0] wd_dbl;
  logic [63:0] rd_dbl;
  logic [31:0] rd_rot;
  logic [31:0] load_result;
  logic [31:0] merge_next;

  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;

  // Classify the incoming request: offset, size, word-crossing and the
  // sticky error decision are all taken from the raw request fields.
  always_comb begin
    req_offset    = bus.REQ_ADDR[1:0];
    req_word      = bus.REQ_ADDR[31:2];
    req_word_next = req_word + 30'd1;
    case (bus.REQ_SIZE)
      2'd0:    req_bytes = 3'd1;
      2'd1:    req_bytes = 3'd2;
      default: req_bytes = 3'd4;
    endcase
    req_cross = (({1'b0, req_offset} + req_bytes) > 3'd4);
    req_err   = (bus.REQ_SIZE == 2'd3)
              || (req_cross && !SPLIT_EN)
              || ({1'b0, req_word} >= DM_WORDS_W)
              || (req_cross && ({1'b0, req_word_next} >= DM_WORDS_W));
  end

  // The lane mask shifted by the offset spans two words: the low nibble
  // are the lanes of the first word, the high nibble those of the second.
  // Write data is rotated so each byte lands on the lane it targets in
  // either word.
  always_comb begin
    case (r_size)
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    lane_span = {4'b0000, size_mask} << r_offset;
    wd_dbl    = {r_wdata, r_wdata} << {r_offset, 3'b000};
  end

  // Memory port drive. RESET suppresses enables combinationally so that a
  // reset landing in the second half of a split store never writes it.
  always_comb begin
    mem_we   = 1'b0;
    mem_be   = 4'b0000;
    mem_addr = r_word;
    case (state)
      ACC0: begin
        if (!r_err) begin
          mem_we = r_write;
          mem_be = lane_span[3:0];
        end
      end
      ACC1: begin
        mem_addr = r_word + 30'd1;
        mem_we   = r_write;
        mem_be   = lane_span[7:4];
      end
      default: begin
        mem_we = 1'b0;
        mem_be = 4'b0000;
      end
    endcase
    if (RESET) begin
      mem_we = 1'b0;
      mem_be = 4'b0000;
    end
  end

  assign bus.DM_WE   = mem_we;
  assign bus.DM_BE   = mem_be;
  assign bus.DM_ADDR = mem_addr;
  assign bus.DM_WD   = wd_dbl[63:32];

  // Replace the enabled lanes of the merge buffer with the read data.
  always_comb begin
    merge_next = merge_buf;
    for (int i = 0; i < 4; i++) begin
      if (mem_be[i]) merge_next[8*i +: 8] = bus.DM_RD[8*i +: 8];
    end
  end

  // Undo the lane rotation, then truncate and extend to the access size.
  always_comb begin
    rd_dbl = {merge_buf, merge_buf} >> {r_offset, 3'b000};
    rd_rot = rd_dbl[31:0];
    case (r_size)
      2'd0:    load_result = r_uns ? {24'h000000, rd_rot[7:0]}
                                   : {{24{rd_rot[7]}}, rd_rot[7:0]};
      2'd1:    load_result = r_uns ? {16'h0000, rd_rot[15:0]}
                                   : {{16{rd_rot[15]}}, rd_rot[15:0]};
      default: load_result = rd_rot;
    endcase
  end

  // Request sequencing: accept in IDLE, one or two memory cycles, then
  // hold the response until it is consumed.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      r_write   <= 1'b0;
      r_size    <= 2'd0;
      r_uns     <= 1'b0;
      r_offset  <= 2'd0;
      r_word    <= 30'd0;
      r_wdata   <= 32'd0;
      r_err     <= 1'b0;
      r_cross   <= 1'b0;
      merge_buf <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.REQ_VALID) begin
            r_write   <= bus.REQ_WRITE;
            r_size    <= bus.REQ_SIZE;
            r_uns     <= bus.REQ_UNS;
            r_offset  <= req_offset;
            r_word    <= req_word;
            r_wdata   <= bus.REQ_WDATA;
            r_err     <= req_err;
            r_cross   <= req_cross;
            merge_buf <= 32'd0;
            state     <= ACC0;
          end
        end
        ACC0: begin
          if (!r_write) merge_buf <= merge_next;
          state <= (r_cross && !r_err) ? ACC1 : RESP;
        end
        ACC1: begin
          if (!r_write) merge_buf <= merge_next;
          state <= RESP;
        end
        RESP: begin
          if (bus.RESP_READY) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.REQ_READY  = (state == IDLE);
  assign bus.RESP_VALID = (state == RESP);
  assign bus.RESP_ERR   = (state == RESP) && r_err;
  assign bus.RESP_DATA  = ((state == RESP) && !r_err && !r_write) ? load_result : 32'd0;

endmodule

// File: tb/tb_dmem_lsu.sv
// ---------------------------------------------------------------------------
// tb_dmem_lsu
// Directed bench for dmem_lsu. Two instances: dut_a splits word-crossing
// accesses, dut_b reports them as errors. Each has a 64-word byte-enabled
// memory model; dut_a's memory-port activity is logged for inspection.
// ---------------------------------------------------------------------------
module tb_dmem_lsu;

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
  } access_t;

  logic clk = 1'b0;
  logic reset;
  int   num_checks = 0;
  int   num_errors = 0;

  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  logic        pre_en_a, pre_en_b;
  logic [5:0]  pre_addr_a, pre_addr_b;
  logic [31:0] pre_data_a, pre_data_b;
  access_t     log_a [$];
  int          activity_b = 0;

  dmem_lsu_if bus_a();
  dmem_lsu_if bus_b();

  dmem_lsu #(.SPLIT_UNALIGNED(1), .DM_WORDS(64)) dut_a (
    .CLK(clk), .RESET(reset), .bus(bus_a.slave)
  );
  dmem_lsu #(.SPLIT_UNALIGNED(0), .DM_WORDS(64)) dut_b (
    .CLK(clk), .RESET(reset), .bus(bus_b.slave)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Combinational read ports; unimplemented words read as zero.
  assign bus_a.DM_RD = (bus_a.DM_ADDR < 30'd64) ? mem_a[bus_a.DM_ADDR[5:0]] : 32'h0;
  assign bus_b.DM_RD = (bus_b.DM_ADDR < 30'd64) ? mem_b[bus_b.DM_ADDR[5:0]] : 32'h0;

  // Memory A: bench preload or byte-enabled write, plus an access log.
  always @(posedge clk) begin
    if (pre_en_a) mem_a[pre_addr_a] <= pre_data_a;
    else if (bus_a.DM_WE && bus_a.DM_ADDR < 30'd64) begin
      for (int i = 0; i < 4; i++)
        if (bus_a.DM_BE[i]) mem_a[bus_a.DM_ADDR[5:0]][8*i +: 8] <= bus_a.DM_WD[8*i +: 8];
    end
    if (bus_a.DM_WE || bus_a.DM_BE != 4'b0000)
      log_a.push_back('{bus_a.DM_ADDR, bus_a.DM_BE, bus_a.DM_WE, bus_a.DM_WD});
  end

  // Memory B: same model; only counts memory-port activity.
  always @(posedge clk) begin
    if (pre_en_b) mem_b[pre_addr_b] <= pre_data_b;
    else if (bus_b.DM_WE && bus_b.DM_ADDR < 30'd64) begin
      for (int i = 0; i < 4; i++)
        if (bus_b.DM_BE[i]) mem_b[bus_b.DM_ADDR[5:0]][8*i +: 8] <= bus_b.DM_WD[8*i +: 8];
    end
    if (bus_b.DM_WE || bus_b.DM_BE != 4'b0000) activity_b++;
  end

  // Global guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic preloadWord(input bit sel, input int idx, input logic [31:0] data);
    @(negedge clk);
    if (sel) begin pre_en_b = 1'b1; pre_addr_b = 6'(idx); pre_data_b = data; end
    else     begin pre_en_a = 1'b1; pre_addr_a = 6'(idx); pre_data_a = data; end
    @(posedge clk);
    #1;
    pre_en_a = 1'b0;
    pre_en_b = 1'b0;
  endtask

  task automatic driveReq(input bit sel, input logic wr, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (sel) begin
      bus_b.REQ_WRITE = wr; bus_b.REQ_SIZE = size; bus_b.REQ_UNS = uns;
      bus_b.REQ_ADDR = addr; bus_b.REQ_WDATA = wdata; bus_b.REQ_VALID = 1'b1;
    end else begin
      bus_a.REQ_WRITE = wr; bus_a.REQ_SIZE = size; bus_a.REQ_UNS = uns;
      bus_a.REQ_ADDR = addr; bus_a.REQ_WDATA = wdata; bus_a.REQ_VALID = 1'b1;
    end
  endtask

  task automatic waitAccept(input bit sel, input string tag);
    bit rdy;
    bit ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rdy = sel ? bus_b.REQ_READY : bus_a.REQ_READY;
      @(posedge clk);
      if (rdy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  // Called #1 after the accept edge; lat counts edges including that one.
  task automatic waitResp(input bit sel, input string tag, output int lat);
    bit vld;
    bit ok = 1'b0;
    lat = 1;
    for (int i = 0; i < 12; i++) begin
      vld = sel ? bus_b.RESP_VALID : bus_a.RESP_VALID;
      if (vld) begin ok = 1'b1; break; end
      @(posedge clk);
      #1;
      lat++;
    end
    if (!ok) checkOutput({tag, "_resp_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input bit sel, input string tag, input logic wr, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] data, output logic err, output int lat);
    @(negedge clk);
    driveReq(sel, wr, size, uns, addr, wdata);
    waitAccept(sel, tag);
    #1;
    bus_a.REQ_VALID = 1'b0;
    bus_b.REQ_VALID = 1'b0;
    waitResp(sel, tag, lat);
    data = sel ? bus_b.RESP_DATA : bus_a.RESP_DATA;
    err  = sel ? bus_b.RESP_ERR  : bus_a.RESP_ERR;
    if (sel) bus_b.RESP_READY = 1'b1; else bus_a.RESP_READY = 1'b1;
    @(posedge clk);
    #1;
    bus_a.RESP_READY = 1'b0;
    bus_b.RESP_READY = 1'b0;
  endtask

  // Directed sequence with hand-computed expectations.
  initial begin
    logic [31:0] d;
    logic        e;
    int          lat;
    int          n0;
    bit          bad;

    reset = 1'b1;
    pre_en_a = 1'b0; pre_en_b = 1'b0;
    pre_addr_a = '0; pre_addr_b = '0; pre_data_a = '0; pre_data_b = '0;
    driveReq(0, 0, 2'd0, 0, 32'h0, 32'h0);
    driveReq(1, 0, 2'd0, 0, 32'h0, 32'h0);
    bus_a.REQ_VALID = 1'b0; bus_b.REQ_VALID = 1'b0;
    bus_a.RESP_READY = 1'b0; bus_b.RESP_READY = 1'b0;

    preloadWord(0, 5,  32'h80FF7F01);
    preloadWord(0, 2,  32'hDDCCBBAA);
    preloadWord(0, 3,  32'h44332211);
    preloadWord(0, 10, 32'h00000000);
    preloadWord(0, 11, 32'h00000000);
    preloadWord(0, 63, 32'hCAFEF00D);
    preloadWord(1, 2,  32'hDDCCBBAA);
    preloadWord(1, 3,  32'h44332211);

    checkOutput("rst_req_ready",  32'(bus_a.REQ_READY),  32'd1);
    checkOutput("rst_resp_valid", 32'(bus_a.RESP_VALID), 32'd0);
    checkOutput("rst_resp_data",  bus_a.RESP_DATA,       32'd0);
    checkOutput("rst_resp_err",   32'(bus_a.RESP_ERR),   32'd0);
    checkOutput("rst_dm_we",      32'(bus_a.DM_WE),      32'd0);
    checkOutput("rst_dm_be",      32'(bus_a.DM_BE),      32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] aligned and sub-word loads");
    applyStimulus(0, "lb",  0, 2'd0, 0, 32'h16, 32'h0, d, e, lat);
    checkOutput("lb_data", d, 32'hFFFFFFFF);
    checkOutput("lb_err", 32'(e), 32'd0);
    applyStimulus(0, "lbu", 0, 2'd0, 1, 32'h16, 32'h0, d, e, lat);
    checkOutput("lbu_data", d, 32'h000000FF);
    applyStimulus(0, "lh",  0, 2'd1, 0, 32'h16, 32'h0, d, e, lat);
    checkOutput("lh_data", d, 32'hFFFF80FF);
    applyStimulus(0, "lw",  0, 2'd2, 0, 32'h14, 32'h0, d, e, lat);
    checkOutput("lw_data", d, 32'h80FF7F01);
    checkOutput("lw_latency", 32'(lat), 32'd2);

    $display("[TB] halfword store");
    n0 = log_a.size();
    applyStimulus(0, "sh", 1, 2'd1, 0, 32'h15, 32'h00001234, d, e, lat);
    checkOutput("sh_access_count", 32'(log_a.size() - n0), 32'd1);
    if (log_a.size() > n0) begin
      checkOutput("sh_addr", 32'(log_a[n0].addr), 32'd5);
      checkOutput("sh_be",   32'(log_a[n0].be),   32'h6);
      checkOutput("sh_we",   32'(log_a[n0].we),   32'd1);
      checkOutput("sh_wd",   log_a[n0].wd,        32'h00123400);
    end
    checkOutput("sh_resp_data", d, 32'd0);
    checkOutput("sh_mem5", mem_a[5], 32'h80123401);

    $display("[TB] word-crossing accesses");
    n0 = log_a.size();
    applyStimulus(0, "lw_x", 0, 2'd2, 0, 32'h0B, 32'h0, d, e, lat);
    checkOutput("lw_x_access_count", 32'(log_a.size() - n0), 32'd2);
    if (log_a.size() >= n0 + 2) begin
      checkOutput("lw_x_addr0", 32'(log_a[n0].addr),   32'd2);
      checkOutput("lw_x_be0",   32'(log_a[n0].be),     32'h8);
      checkOutput("lw_x_addr1", 32'(log_a[n0+1].addr), 32'd3);
      checkOutput("lw_x_be1",   32'(log_a[n0+1].be),   32'h7);
    end
    checkOutput("lw_x_data", d, 32'h332211DD);
    checkOutput("lw_x_latency", 32'(lat), 32'd3);
    applyStimulus(0, "sw_x", 1, 2'd2, 0, 32'h0B, 32'hA1B2C3D4, d, e, lat);
    checkOutput("sw_x_mem2", mem_a[2], 32'hD4CCBBAA);
    checkOutput("sw_x_mem3", mem_a[3], 32'h44A1B2C3);
    checkOutput("sw_x_latency", 32'(lat), 32'd3);
    applyStimulus(0, "lhu_x", 0, 2'd1, 1, 32'h0B, 32'h0, d, e, lat);
    checkOutput("lhu_x_data", d, 32'h0000C3D4);
    applyStimulus(0, "lh_x", 0, 2'd1, 0, 32'h0B, 32'h0, d, e, lat);
    checkOutput("lh_x_data", d, 32'hFFFFC3D4);

    $display("[TB] range boundaries");
    applyStimulus(0, "lw_top", 0, 2'd2, 0, 32'hFC, 32'h0, d, e, lat);
    checkOutput("lw_top_data", d, 32'hCAFEF00D);
    checkOutput("lw_top_err", 32'(e), 32'd0);
    n0 = log_a.size();
    applyStimulus(0, "lw_past_top", 0, 2'd2, 0, 32'hFE, 32'h0, d, e, lat);
    checkOutput("lw_past_top_err", 32'(e), 32'd1);
    checkOutput("lw_past_top_data", d, 32'd0);
    applyStimulus(0, "sw_oor_a", 1, 2'd2, 0, 32'h100, 32'h12345678, d, e, lat);
    checkOutput("sw_oor_a_err", 32'(e), 32'd1);
    checkOutput("oor_a_access_count", 32'(log_a.size() - n0), 32'd0);

    $display("[TB] no-split instance");
    applyStimulus(1, "b_lw_x", 0, 2'd2, 0, 32'h0B, 32'h0, d, e, lat);
    checkOutput("b_lw_x_err", 32'(e), 32'd1);
    checkOutput("b_lw_x_data", d, 32'd0);
    checkOutput("b_lw_x_latency", 32'(lat), 32'd2);
    applyStimulus(1, "b_size3", 0, 2'd3, 0, 32'h10, 32'h0, d, e, lat);
    checkOutput("b_size3_err", 32'(e), 32'd1);
    checkOutput("b_size3_data", d, 32'd0);
    applyStimulus(1, "b_sw_oor", 1, 2'd2, 0, 32'h100, 32'hFFFFFFFF, d, e, lat);
    checkOutput("b_sw_oor_err", 32'(e), 32'd1);
    checkOutput("b_activity", 32'(activity_b), 32'd0);
    checkOutput("b_mem2", mem_b[2], 32'hDDCCBBAA);
    checkOutput("b_mem3", mem_b[3], 32'h44332211);
    applyStimulus(1, "b_lh_edge", 0, 2'd1, 0, 32'h0A, 32'h0, d, e, lat);
    checkOutput("b_lh_edge_data", d, 32'hFFFFDDCC);
    checkOutput("b_lh_edge_err", 32'(e), 32'd0);

    $display("[TB] response back-pressure");
    @(negedge clk);
    driveReq(0, 0, 2'd2, 0, 32'h14, 32'h0);
    waitAccept(0, "stall");
    #1;
    driveReq(0, 0, 2'd0, 1, 32'h16, 32'h0);
    waitResp(0, "stall", lat);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_resp_valid", 32'(bus_a.RESP_VALID), 32'd1);
      checkOutput("stall_resp_data",  bus_a.RESP_DATA,       32'h80123401);
      checkOutput("stall_req_ready",  32'(bus_a.REQ_READY),  32'd0);
      @(posedge clk);
      #1;
    end
    bus_a.RESP_READY = 1'b1;
    @(posedge clk);
    #1;
    bus_a.RESP_READY = 1'b0;
    checkOutput("handshake_req_ready",  32'(bus_a.REQ_READY),  32'd1);
    checkOutput("handshake_resp_valid", 32'(bus_a.RESP_VALID), 32'd0);
    @(posedge clk);
    #1;
    bus_a.REQ_VALID = 1'b0;
    checkOutput("next_accepted", 32'(bus_a.REQ_READY), 32'd0);
    waitResp(0, "next", lat);
    checkOutput("next_data", bus_a.RESP_DATA, 32'h00000012);
    checkOutput("next_latency", 32'(lat), 32'd2);
    bus_a.RESP_READY = 1'b1;
    @(posedge clk);
    #1;
    bus_a.RESP_READY = 1'b0;

    $display("[TB] reset during second half of a split store");
    n0 = log_a.size();
    @(negedge clk);
    driveReq(0, 1, 2'd2, 0, 32'h2A, 32'hCAFEBABE);
    waitAccept(0, "rst_sw");
    #1;
    bus_a.REQ_VALID = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("acc1_we", 32'(bus_a.DM_WE), 32'd1);
    checkOutput("acc1_be", 32'(bus_a.DM_BE), 32'h3);
    reset = 1'b1;
    driveReq(0, 0, 2'd2, 0, 32'h14, 32'h0);
    #1;
    checkOutput("rst_acc1_we", 32'(bus_a.DM_WE), 32'd0);
    checkOutput("rst_acc1_be", 32'(bus_a.DM_BE), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("post_rst_we",         32'(bus_a.DM_WE),      32'd0);
    checkOutput("post_rst_resp_valid", 32'(bus_a.RESP_VALID), 32'd0);
    checkOutput("post_rst_req_ready",  32'(bus_a.REQ_READY),  32'd1);
    @(posedge clk);
    #1;
    checkOutput("rst_no_accept", 32'(bus_a.REQ_READY), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    bus_a.REQ_VALID = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (bus_a.RESP_VALID || !bus_a.REQ_READY) bad = 1'b1;
    end
    checkOutput("abandoned_quiet", 32'(bad), 32'd0);
    checkOutput("rst_mem10", mem_a[10], 32'hBABE0000);
    checkOutput("rst_mem11", mem_a[11], 32'h00000000);
    checkOutput("rst_access_count", 32'(log_a.size() - n0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
